// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, event encoding and row/column decode for the keypad event path
package keypad_pkg;
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;
  typedef struct packed {
    logic       kind;
    logic [3:0] code;
  } evt_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } sample_t;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  function automatic logic [2:0] onehot4_to_idx(input logic [3:0] v);
    return (v == 4'b0001) ? 3'b100 :
           (v == 4'b0010) ? 3'b101 :
           (v == 4'b0100) ? 3'b110 :
           (v == 4'b1000) ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: small synchronous event FIFO with drop-on-full and sticky overflow flag
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_ovf_clr,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  assign w_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_ovf   = r_ovf;
  // pointers, occupancy and overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wr  <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf <= w_drop | (r_ovf & ~i_ovf_clr);
    end
  end
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: debounces scanner key outputs and queues press/release events
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int FIFO_DEPTH = 4,
  parameter bit REPORT_RELEASE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_pressed,
  input  logic [3:0] col_pressed,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic       key_held,
  output logic       ovf,
  input  logic       ovf_clr
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [2:0] w_row;
  logic [2:0] w_col;
  sample_t    w_dec;
  sample_t    w_cand_s;
  sample_t    w_held_s;
  logic       w_stable;
  logic       w_press_done;
  logic       w_release_done;
  logic       w_push;
  logic       w_empty;
  evt_t       w_evt;
  sample_t    r_sample;
  logic [15:0] r_cnt;
  state_t     r_state;
  logic [3:0] r_cand;
  logic [3:0] r_held_code;
  logic       r_key_held;
  assign w_row          = onehot4_to_idx(row_pressed);
  assign w_col          = onehot4_to_idx(col_pressed);
  assign w_dec          = (w_row[2] & w_col[2]) ? sample_t'({1'b1, w_col[1:0], w_row[1:0]}) : '0;
  assign w_cand_s       = sample_t'({1'b1, r_cand});
  assign w_held_s       = sample_t'({1'b1, r_held_code});
  assign w_stable       = (r_cnt == CNT_MAX) && (w_dec == r_sample);
  assign w_press_done   = (r_state == DEB_PRESS) && (r_sample == w_cand_s) && w_stable;
  assign w_release_done = (r_state == DEB_RELEASE) && (r_sample != w_held_s) && w_stable;
  assign w_push         = w_press_done | (w_release_done & REPORT_RELEASE);
  assign w_evt          = w_press_done ? evt_t'({EVT_PRESS, r_cand}) : evt_t'({EVT_RELEASE, r_held_code});
  assign evt_valid      = ~w_empty;
  assign key_held       = r_key_held;
  // previous-cycle sample and run length of identical samples, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_cnt    <= '0;
    end else begin
      r_sample <= w_dec;
      r_cnt    <= (w_dec != r_sample) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 16'd1;
    end
  end
  // press/release debounce state machine with registered held indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_held_code <= '0;
      r_key_held  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sample.valid) begin
            r_state <= DEB_PRESS;
            r_cand  <= r_sample.code;
          end
        end
        DEB_PRESS: begin
          if (r_sample != w_cand_s) r_state <= IDLE;
          else if (w_stable) begin
            r_state     <= HELD;
            r_held_code <= r_cand;
            r_key_held  <= 1'b1;
          end
        end
        HELD: begin
          if (r_sample != w_held_s) r_state <= DEB_RELEASE;
        end
        DEB_RELEASE: begin
          if (r_sample == w_held_s) r_state <= HELD;
          else if (w_stable) begin
            r_state    <= IDLE;
            r_key_held <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  keypad_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(5)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (w_evt),
    .i_pop     (evt_ready),
    .i_ovf_clr (ovf_clr),
    .o_data    (evt_data),
    .o_empty   (w_empty),
    .o_ovf     (ovf)
  );
endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
Sits downstream of the 4x4 column-scan keypad scanner. Consumes its registered rowPressed/colPressed outputs. Debounces them, encodes each key to a 4-bit code, and queues press/release events in a small FIFO for the host logic to read with a valid/ready handshake. Single clock domain, same clock as the scanner.

Parameters:
DEBOUNCE_CYCLES, 256, consecutive identical samples required to confirm a press or a release (legal range 2..65535)
FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16)
REPORT_RELEASE, 1, 1 = queue release events; 0 = queue press events only

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
row_pressed  in  4  row bits from scanner (one-hot or zero)
col_pressed  in  4  column bits from scanner (one-hot or zero)
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts head event when evt_valid=1
evt_data  out  5  [4]=1 press / 0 release; [3:0]=key code
key_held  out  1  a confirmed key is currently held
ovf  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears ovf (push-drop in the same cycle wins; ovf stays 1)

Behaviour:
- Reset (rst_n=0, async): state IDLE; sample, counter and FIFO pointers are zero; evt_valid=0, evt_data=0, key_held=0, ovf=0.
- Decode (combinational): a valid key has exactly one row bit and one column bit set. code = {col_idx[1:0], row_idx[1:0]}, where idx is the bit position. Any other pattern, including zero or multi-bit, decodes as NONE.
- sample_q register: holds {valid, code} from the previous clock. cnt resets to 0 whenever the new decode differs from sample_q; otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
- "Stable" means cnt==DEBOUNCE_CYCLES-1 and decode==sample_q in this cycle.
- FSM states and transitions:
  - IDLE: sample_q valid -> DEB_PRESS (cand=sample_q.code).
  - DEB_PRESS: sample differs from cand -> IDLE. Stable on cand -> push {1,cand}; held_code=cand; go to HELD.
  - HELD: key_held=1. Sample != held_code (NONE or another key) -> DEB_RELEASE.
  - DEB_RELEASE: key_held=1. Sample returns to held_code -> HELD, no event. Stable on anything other than held_code -> push {0,held_code} if REPORT_RELEASE; key_held drops; go to IDLE. A new key that is already present is then debounced from scratch.
- Latency: a key presented cleanly at cycle 0 produces evt_valid=1 after edge DEBOUNCE_CYCLES+1.
- FIFO behaviour:
  - Pop occurs when evt_valid and evt_ready are both 1.
  - Push when full and no pop: event dropped, ovf<=1.
  - Push and pop in the same cycle while full: both accepted, occupancy unchanged, no overflow.
  - evt_data shows the head entry, is stable while evt_valid=1 and evt_ready=0, and is 0 when empty.
  - evt_ready while empty is ignored.
- Reset mid-debounce or with the FIFO non-empty discards everything; no release event is generated for a key held at reset.
- Scanner's inter-scan zero gaps: the scanner only clears its outputs after a complete empty scan, so a held key is seen as continuous. Debounce absorbs one-scan glitches when DEBOUNCE_CYCLES exceeds the scan period of 80 clocks.

Decomposition:
- Shared package keypad_pkg holds:
  - EVT_PRESS/EVT_RELEASE constants
  - 5-bit event typedef {kind, code}
  - FSM state enum {IDLE, DEB_PRESS, HELD, DEB_RELEASE}
  - decode function onehot4_to_idx (returns valid + 2-bit idx)
- One sub-module, keypad_evt_fifo: synchronous FIFO, parameterised depth/width, with push/pop/full/empty/overflow ports. The FSM, debounce counter and decode stay in keypad_event_ctrl.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4.
- Clean press: row=0010, col=0100 held 20 clocks, evt_ready=0 -> evt_valid rises after edge 5, evt_data=5'h19, key_held=1; no further events while held.
- Release: from the held state, drive row=col=0 for 10 clocks with evt_ready=1 -> second event 5'h09 and key_held=0. With REPORT_RELEASE=0, only 5'h19 is ever produced.
- Bounce rejection: row toggles 0001/0000 every 2 clocks for 20 clocks (col=0001) -> no event. Then hold for 5 clocks -> single event 5'h10.
- Invalid pattern: row=0011, col=0001 held 20 clocks -> no event, key_held=0. Then row=1000 -> event 5'h13.
- Overflow: FIFO_DEPTH=4, evt_ready=0, five press/release pairs of distinct keys -> 4 events queued, ovf=1. Draining returns the first four in order. ovf_clr -> ovf=0.
- Async reset while in DEB_RELEASE with 2 queued events -> evt_valid=0 and key_held=0 immediately (before the next clk edge); no release event after reset is deasserted.
